// File: rtl/keypad_lock_sequencer.sv
// Keypad front-end for the digit-lock datapath: digit-cell writes,
// compare/clear strobes, unlock, lockout and password change.
module keypad_lock_sequencer #(
   parameter int MAX_DIGITS  = 6,
   parameter int MIN_DIGITS  = 4,
   parameter int OPEN_CYCLES = 1000,
   parameter int LOCK_CYCLES = 5000,
   parameter int MAX_FAILS   = 3,
   parameter int CMP_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  key_valid,
   input  logic [3:0]            key_code,
   input  logic                  match,
   output logic [3:0]            st_data,
   output logic [MAX_DIGITS-1:0] st_cs,
   output logic                  st_wr_in,
   output logic                  st_in_clr,
   output logic                  st_ans_wr,
   output logic                  st_ans_init,
   output logic                  st_compare,
   output logic [2:0]            digit_count,
   output logic [1:0]            fail_count,
   output logic                  unlock,
   output logic                  alarm,
   output logic                  key_err
);

   typedef enum logic [2:0] {
      S_ENTRY, S_CHECK, S_WAIT, S_OPEN,
      S_SET, S_SET_CLR, S_LOCK
   } state_t;

   localparam logic [2:0]  MAX_D   = 3'(MAX_DIGITS);
   localparam logic [2:0]  MIN_D   = 3'(MIN_DIGITS);
   localparam logic [1:0]  MAX_F   = 2'(MAX_FAILS);
   localparam logic [12:0] OPEN_LD = 13'(OPEN_CYCLES - 1);
   localparam logic [12:0] LOCK_LD = 13'(LOCK_CYCLES - 1);
   localparam logic [12:0] CMP_LD  = 13'(CMP_LAT);
   localparam logic [MAX_DIGITS-1:0] CS_ONE = MAX_DIGITS'(1);

   state_t                state, state_n;
   logic [12:0]           timer, timer_n;
   logic [2:0]            ans_len, ans_len_n;
   logic [2:0]            cnt_n;
   logic [1:0]            fail_n, fail_inc;
   logic [3:0]            data_n;
   logic [MAX_DIGITS-1:0] cs_n;
   logic                  wr_n, clr_n, ans_wr_n, cmp_n, err_n;
   logic                  unlock_n, alarm_n;
   logic                  is_dig, is_star, is_hash, tmr_zero;
   logic                  take_dig;

   assign is_dig   = key_valid && (key_code <= 4'd9);
   assign is_star  = key_valid && (key_code == 4'hA);
   assign is_hash  = key_valid && (key_code == 4'hB);
   assign tmr_zero = (timer == '0);
   assign fail_inc = (fail_count == MAX_F) ? fail_count
                                           : fail_count + 2'd1;

   always_comb begin
      state_n   = state;
      timer_n   = timer;
      ans_len_n = ans_len;
      cnt_n     = digit_count;
      fail_n    = fail_count;
      data_n    = st_data;
      cs_n      = '0;
      wr_n      = 1'b0;
      clr_n     = 1'b0;
      ans_wr_n  = 1'b0;
      cmp_n     = 1'b0;
      err_n     = 1'b0;
      unlock_n  = unlock;
      alarm_n   = alarm;
      take_dig  = 1'b0;

      unique case (state)
         S_ENTRY: begin
            unique case (1'b1)
               is_dig: take_dig = 1'b1;
               is_star: begin
                  if (digit_count >= MIN_D) begin
                     state_n = S_CHECK;
                  end else begin
                     err_n = 1'b1;
                     clr_n = 1'b1;
                     cnt_n = '0;
                  end
               end
               is_hash: begin
                  clr_n = 1'b1;
                  cnt_n = '0;
               end
               default: ;
            endcase
         end
         S_CHECK: begin
            cmp_n   = 1'b1;
            timer_n = CMP_LD;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            if (!tmr_zero) begin
               timer_n = timer - 13'd1;
            end else begin
               clr_n = 1'b1;
               cnt_n = '0;
               if (match && (digit_count == ans_len)) begin
                  state_n  = S_OPEN;
                  fail_n   = '0;
                  unlock_n = 1'b1;
                  timer_n  = OPEN_LD;
               end else if (fail_inc == MAX_F) begin
                  state_n = S_LOCK;
                  fail_n  = fail_inc;
                  alarm_n = 1'b1;
                  timer_n = LOCK_LD;
               end else begin
                  state_n = S_ENTRY;
                  fail_n  = fail_inc;
               end
            end
         end
         S_OPEN: begin
            if (tmr_zero) begin
               state_n  = S_ENTRY;
               unlock_n = 1'b0;
            end else if (is_hash) begin
               state_n  = S_SET;
               unlock_n = 1'b0;
               timer_n  = OPEN_LD;
            end else begin
               timer_n = timer - 13'd1;
            end
         end
         S_SET: begin
            // expiry outranks a key arriving in the same cycle
            if (tmr_zero) begin
               clr_n   = 1'b1;
               cnt_n   = '0;
               state_n = S_ENTRY;
            end else if (key_valid) begin
               timer_n = OPEN_LD;
               unique case (1'b1)
                  is_dig: take_dig = 1'b1;
                  is_star: begin
                     clr_n   = 1'b1;
                     cnt_n   = '0;
                     state_n = S_ENTRY;
                  end
                  is_hash: begin
                     if (digit_count >= MIN_D) begin
                        ans_wr_n  = 1'b1;
                        ans_len_n = digit_count;
                        state_n   = S_SET_CLR;
                     end else begin
                        err_n = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end else begin
               timer_n = timer - 13'd1;
            end
         end
         S_SET_CLR: begin
            clr_n   = 1'b1;
            cnt_n   = '0;
            state_n = S_ENTRY;
         end
         S_LOCK: begin
            if (tmr_zero) begin
               state_n = S_ENTRY;
               fail_n  = '0;
               alarm_n = 1'b0;
            end else begin
               timer_n = timer - 13'd1;
            end
         end
         default: state_n = S_ENTRY;
      endcase

      if (take_dig) begin
         if (digit_count < MAX_D) begin
            data_n = key_code;
            cs_n   = CS_ONE << digit_count;
            wr_n   = 1'b1;
            cnt_n  = digit_count + 3'd1;
         end else begin
            err_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_ENTRY;
         timer       <= '0;
         ans_len     <= MIN_D;
         digit_count <= '0;
         fail_count  <= '0;
         st_data     <= '0;
         st_cs       <= '0;
         st_wr_in    <= 1'b0;
         st_in_clr   <= 1'b1;
         st_ans_wr   <= 1'b0;
         st_ans_init <= 1'b1;
         st_compare  <= 1'b0;
         unlock      <= 1'b0;
         alarm       <= 1'b0;
         key_err     <= 1'b0;
      end else begin
         state       <= state_n;
         timer       <= timer_n;
         ans_len     <= ans_len_n;
         digit_count <= cnt_n;
         fail_count  <= fail_n;
         st_data     <= data_n;
         st_cs       <= cs_n;
         st_wr_in    <= wr_n;
         st_in_clr   <= clr_n;
         st_ans_wr   <= ans_wr_n;
         st_ans_init <= 1'b0;
         st_compare  <= cmp_n;
         unlock      <= unlock_n;
         alarm       <= alarm_n;
         key_err     <= err_n;
      end
   end

endmodule

// File: tb/tb_keypad_lock_sequencer.sv
// Directed self-checking bench for keypad_lock_sequencer.
// Strobes are tallied at negedge; checks run 1ns after posedge.
module tb_keypad_lock_sequencer;

   logic       clk = 1'b0;
   logic       reset_n, key_valid, match;
   logic [3:0] key_code;
   logic [3:0] st_data;
   logic [5:0] st_cs;
   logic       st_wr_in, st_in_clr, st_ans_wr;
   logic       st_ans_init, st_compare;
   logic [2:0] digit_count;
   logic [1:0] fail_count;
   logic       unlock, alarm, key_err;

   keypad_lock_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .key_valid(key_valid), .key_code(key_code),
      .match(match), .st_data(st_data), .st_cs(st_cs),
      .st_wr_in(st_wr_in), .st_in_clr(st_in_clr),
      .st_ans_wr(st_ans_wr), .st_ans_init(st_ans_init),
      .st_compare(st_compare), .digit_count(digit_count),
      .fail_count(fail_count), .unlock(unlock),
      .alarm(alarm), .key_err(key_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int n_wr = 0, n_clr = 0, n_ans = 0, n_cmp = 0;
   int n_err = 0, n_multi = 0, n_ans_clr = 0;
   logic prev_ans = 1'b0;
   logic [5:0] cs_q[$];

   always @(negedge clk) begin
      if (reset_n) begin
         if (st_wr_in) begin
            n_wr <= n_wr + 1;
            cs_q.push_back(st_cs);
         end
         if (st_in_clr)  n_clr <= n_clr + 1;
         if (st_ans_wr)  n_ans <= n_ans + 1;
         if (st_compare) n_cmp <= n_cmp + 1;
         if (key_err)    n_err <= n_err + 1;
         if (int'(st_wr_in) + int'(st_in_clr) +
             int'(st_ans_wr) + int'(st_compare) > 1)
            n_multi <= n_multi + 1;
         if (prev_ans && st_in_clr) n_ans_clr <= n_ans_clr + 1;
         prev_ans <= st_ans_wr;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key_code  = k;
      key_valid = 1'b1;
      tick(1);
      key_valid = 1'b0;
      tick(1);
   endtask

   task automatic keys(input logic [31:0] seq, input int n);
      for (int i = 0; i < n; i++) press(seq[4*(n-1-i) +: 4]);
   endtask

   task automatic wait_unlock();
      for (int i = 0; i < 20 && !unlock; i++) tick(1);
   endtask

   int b_wr, b_cs, b_cmp, b_err, b_clr, b_ans, b_ac, n, mx;

   initial begin
      reset_n = 1'b0; key_valid = 1'b0;
      key_code = '0;  match = 1'b1;
      #12;
      chk("rst_ans_init", st_ans_init, 1);
      chk("rst_in_clr", st_in_clr, 1);
      chk("rst_count", digit_count, 0);
      chk("rst_unlock", unlock, 0);
      chk("rst_alarm", alarm, 0);
      chk("rst_wr", st_wr_in, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      #2 chk("rel_ans_init_hold", st_ans_init, 1);
      @(posedge clk); #1;
      chk("rel_ans_init", st_ans_init, 0);
      chk("rel_in_clr", st_in_clr, 0);

      // default code 0000
      b_wr = n_wr; b_cs = cs_q.size(); b_cmp = n_cmp;
      keys(32'h0000, 4);
      chk("t1_count", digit_count, 4);
      press(4'hA);
      wait_unlock();
      chk("t1_unlock", unlock, 1);
      chk("t1_wr", n_wr - b_wr, 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t1_cs%0d", i), int'(cs_q[b_cs+i]), 1 << i);
      chk("t1_cmp", n_cmp - b_cmp, 1);
      n = 0;
      while (unlock && n < 1100) begin n++; tick(1); end
      chk("t1_open_len", n, 1000);

      // short code
      b_err = n_err; b_clr = n_clr; b_cmp = n_cmp;
      keys(32'h12A, 3);
      tick(2);
      chk("t2_err", n_err - b_err, 1);
      chk("t2_clr", n_clr - b_clr, 1);
      chk("t2_cmp", n_cmp - b_cmp, 0);
      chk("t2_count", digit_count, 0);

      // three failures -> lockout
      match = 1'b0;
      for (int a = 1; a <= 3; a++) begin
         keys(32'h1111A, 5);
         tick(4);
         chk($sformatf("t3_fail%0d", a), fail_count, a);
         chk($sformatf("t3_alarm%0d", a), alarm, a == 3 ? 1 : 0);
      end
      b_err = n_err; b_wr = n_wr;
      key_code = 4'd5; n = 0;
      while (alarm && n < 6000) begin
         key_valid = (n == 10);
         n++;
         tick(1);
      end
      key_valid = 1'b0;
      chk("t3_lock_len", n, 4998);
      chk("t3_err", n_err - b_err, 0);
      chk("t3_wr", n_wr - b_wr, 0);
      chk("t3_fail_clr", fail_count, 0);

      // password change to 98765
      match = 1'b1;
      keys(32'h0000A, 5);
      wait_unlock();
      chk("t4_unlock", unlock, 1);
      b_ans = n_ans; b_ac = n_ans_clr; b_err = n_err;
      press(4'hB);
      chk("t4_set_unlock", unlock, 0);
      keys(32'h98765B, 6);
      tick(2);
      chk("t4_ans_wr", n_ans - b_ans, 1);
      chk("t4_ans_clr", n_ans_clr - b_ac, 1);
      chk("t4_err", n_err - b_err, 0);
      chk("t4_count", digit_count, 0);
      keys(32'h9876A, 5);
      tick(4);
      chk("t4_len_fail", fail_count, 1);
      chk("t4_len_unlock", unlock, 0);
      keys(32'h98765A, 6);
      wait_unlock();
      chk("t4_new_unlock", unlock, 1);
      chk("t4_new_fail", fail_count, 0);
      b_ans = n_ans; b_err = n_err;
      press(4'hB);
      keys(32'h12B, 3);
      chk("t4_short_err", n_err - b_err, 1);
      chk("t4_short_ans", n_ans - b_ans, 0);
      chk("t4_short_count", digit_count, 2);
      press(4'hA);
      chk("t4_abort_count", digit_count, 0);
      keys(32'h98765A, 6);
      wait_unlock();
      chk("t4_kept_unlock", unlock, 1);
      n = 0;
      while (unlock && n < 1100) begin n++; tick(1); end
      chk("t4_expire", unlock, 0);

      // overflow digit
      b_err = n_err; b_wr = n_wr; b_cs = cs_q.size();
      keys(32'h1234567, 7);
      chk("t5_err", n_err - b_err, 1);
      chk("t5_wr", n_wr - b_wr, 6);
      mx = 0;
      for (int i = b_cs; i < cs_q.size(); i++)
         if (int'(cs_q[i]) > mx) mx = int'(cs_q[i]);
      chk("t5_cs_max", mx, 32);
      chk("t5_count", digit_count, 6);
      press(4'hB);
      chk("t5_clear", digit_count, 0);

      // reset in the middle of a check
      keys(32'h1234A, 5);
      reset_n = 1'b0;
      #2;
      chk("t6_cmp", st_compare, 0);
      chk("t6_clr", st_in_clr, 1);
      chk("t6_init", st_ans_init, 1);
      chk("t6_count", digit_count, 0);
      tick(1);
      reset_n = 1'b1;
      #2 chk("t6_init_hold", st_ans_init, 1);
      @(posedge clk); #1;
      chk("t6_init_drop", st_ans_init, 0);
      keys(32'h0000A, 5);
      wait_unlock();
      chk("t6_default_code", unlock, 1);

      chk("one_strobe", n_multi, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
